// File: rtl/jtframe_dump_ctrl_if.sv
// Bus bundle for the frame-windowed dump controller: timing/download/config
// inputs toward the controller and the capture-window status back out.
interface jtframe_dump_ctrl_if #(
   parameter int CW = 32,
   parameter int LW = 16
);
   logic          vs;
   logic          dwn;
   logic          arm;
   logic          cfg_we;
   logic [CW-1:0] cfg_start;
   logic [LW-1:0] cfg_len;
   logic [CW-1:0] frame_cnt;
   logic          dump_en;
   logic          dump_on;
   logic          dump_off;
   logic [1:0]    st;

   modport master (
      output vs, dwn, arm, cfg_we, cfg_start, cfg_len,
      input  frame_cnt, dump_en, dump_on, dump_off, st
   );

   modport slave (
      input  vs, dwn, arm, cfg_we, cfg_start, cfg_len,
      output frame_cnt, dump_en, dump_on, dump_off, st
   );
endinterface

// File: rtl/jtframe_dump_ctrl.sv
// Frame-windowed capture scheduler: counts frames on vs falling edges and opens
// a dump window at a programmed frame for a programmed number of frames.
module jtframe_dump_ctrl #(
   parameter int CW = 32,
   parameter int LW = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   jtframe_dump_ctrl_if.slave   bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DUMP  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [LW-1:0] REM_ONE = {{(LW-1){1'b0}}, 1'b1};

   logic          s1_r, s2_r, s3_r;
   logic          vs_fall_s;
   logic [CW-1:0] frame_cnt_r;
   logic [CW-1:0] start_r;
   logic [LW-1:0] len_r;
   logic [LW-1:0] rem_r;
   state_t        st_r;
   logic          dump_en_r, dump_on_r, dump_off_r;
   logic          stop_s;
   logic          match_s;

   assign vs_fall_s = s3_r & ~s2_r;
   assign stop_s    = bus.dwn | ~bus.arm;
   assign match_s   = vs_fall_s & (frame_cnt_r == start_r);

   // vs synchronizer plus edge-detect stage; idles high so reset never fakes an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r <= 1'b1;
         s2_r <= 1'b1;
         s3_r <= 1'b1;
      end else begin
         s1_r <= bus.vs;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   // Frame counter, held at zero for the whole download
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_r <= {CW{1'b0}};
      end else if (bus.dwn) begin
         frame_cnt_r <= {CW{1'b0}};
      end else if (vs_fall_s) begin
         frame_cnt_r <= frame_cnt_r + CNT_ONE;
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   // Window sequencer with registered status and one-cycle open/close pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_r       <= IDLE;
         start_r    <= {CW{1'b0}};
         len_r      <= {LW{1'b0}};
         rem_r      <= {LW{1'b0}};
         dump_en_r  <= 1'b0;
         dump_on_r  <= 1'b0;
         dump_off_r <= 1'b0;
      end else begin
         dump_on_r  <= 1'b0;
         dump_off_r <= 1'b0;
         case (st_r)
            IDLE: begin
               if (bus.cfg_we) begin
                  start_r <= bus.cfg_start;
                  len_r   <= bus.cfg_len;
               end
               if (bus.arm && !bus.dwn) begin
                  st_r <= ARMED;
               end
            end
            ARMED: begin
               // Disarm or download outranks a same-cycle start match
               if (stop_s) begin
                  st_r <= IDLE;
               end else if (match_s) begin
                  st_r      <= DUMP;
                  rem_r     <= len_r;
                  dump_en_r <= 1'b1;
                  dump_on_r <= 1'b1;
               end
            end
            DUMP: begin
               if (stop_s || (vs_fall_s && rem_r == REM_ONE)) begin
                  st_r       <= DONE;
                  rem_r      <= {LW{1'b0}};
                  dump_en_r  <= 1'b0;
                  dump_off_r <= 1'b1;
               end else if (vs_fall_s && rem_r != {LW{1'b0}}) begin
                  rem_r <= rem_r - REM_ONE;
               end
            end
            DONE: begin
               if (!bus.arm) begin
                  st_r <= IDLE;
               end
            end
            default: begin
               st_r      <= IDLE;
               dump_en_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.frame_cnt = frame_cnt_r;
   assign bus.dump_en   = dump_en_r;
   assign bus.dump_on   = dump_on_r;
   assign bus.dump_off  = dump_off_r;
   assign bus.st        = st_r;
endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Directed bench for jtframe_dump_ctrl: full-width instance for the main
// scenarios plus a 3-bit counter instance to reach the wrap boundary quickly.
module tb_jtframe_dump_ctrl;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   int   on_cnt, off_cnt, both_cnt, on2_cnt;
   logic [31:0] on_frame, off_frame;
   int   on_base, off_base;

   jtframe_dump_ctrl_if #(.CW(32), .LW(16)) bus ();
   jtframe_dump_ctrl_if #(.CW(3),  .LW(4))  bus2 ();

   jtframe_dump_ctrl #(.CW(32), .LW(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   jtframe_dump_ctrl #(.CW(3), .LW(4)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor: counts open/close pulses and the frame seen alongside them
   always @(negedge clk) begin
      if (bus.dump_on) begin
         on_cnt   <= on_cnt + 1;
         on_frame <= bus.frame_cnt;
      end
      if (bus.dump_off) begin
         off_cnt   <= off_cnt + 1;
         off_frame <= bus.frame_cnt;
      end
      if (bus.dump_on && bus.dump_off) both_cnt <= both_cnt + 1;
      if (bus2.dump_on) on2_cnt <= on2_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic frame();
      bus.vs  = 1'b0;
      bus2.vs = 1'b0;
      repeat (4) @(negedge clk);
      bus.vs  = 1'b1;
      bus2.vs = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic zero_cnt();
      bus.dwn = 1'b1;
      repeat (2) @(negedge clk);
      bus.dwn = 1'b0;
      @(negedge clk);
   endtask

   task automatic cfg(input logic [31:0] start, input logic [15:0] len);
      bus.cfg_start = start;
      bus.cfg_len   = len;
      bus.cfg_we    = 1'b1;
      @(negedge clk);
      bus.cfg_we    = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      on_cnt = 0; off_cnt = 0; both_cnt = 0; on2_cnt = 0;
      on_frame = 32'd0; off_frame = 32'd0;
      rst_n = 1'b0;
      bus.vs = 1'b1; bus.dwn = 1'b0; bus.arm = 1'b0; bus.cfg_we = 1'b0;
      bus.cfg_start = 32'd0; bus.cfg_len = 16'd0;
      bus2.vs = 1'b1; bus2.dwn = 1'b0; bus2.arm = 1'b0; bus2.cfg_we = 1'b0;
      bus2.cfg_start = 3'd0; bus2.cfg_len = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_frame_cnt", bus.frame_cnt, 64'd0);
      chk("rst_st",        bus.st,        64'd0);
      chk("rst_dump_en",   bus.dump_en,   64'd0);
      chk("rst_dump_on",   bus.dump_on,   64'd0);
      chk("rst_dump_off",  bus.dump_off,  64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Frame counting and three-clock latency
      bus.vs = 1'b0; bus2.vs = 1'b0;
      repeat (2) @(negedge clk);
      chk("lat_before", bus.frame_cnt, 64'd0);
      @(negedge clk);
      chk("lat_after", bus.frame_cnt, 64'd1);
      @(negedge clk);
      bus.vs = 1'b1; bus2.vs = 1'b1;
      repeat (4) @(negedge clk);
      frames(4);
      chk("cnt5", bus.frame_cnt, 64'd5);
      chk("cnt5_st", bus.st, 64'd0);
      chk("cnt5_en", bus.dump_en, 64'd0);

      // Start 3, length 2
      zero_cnt();
      chk("dwn_zero", bus.frame_cnt, 64'd0);
      cfg(32'd3, 16'd2);
      bus.arm = 1'b1;
      @(negedge clk);
      chk("armed", bus.st, 64'd1);
      on_base = on_cnt; off_base = off_cnt;
      frames(3);
      chk("w1_pre_st", bus.st, 64'd1);
      chk("w1_pre_en", bus.dump_en, 64'd0);
      frame();
      chk("w1_on_st", bus.st, 64'd2);
      chk("w1_on_en", bus.dump_en, 64'd1);
      chk("w1_on_cnt", on_cnt - on_base, 64'd1);
      chk("w1_on_frame", on_frame, 64'd4);
      frame();
      chk("w1_mid_en", bus.dump_en, 64'd1);
      frame();
      chk("w1_done_st", bus.st, 64'd3);
      chk("w1_done_en", bus.dump_en, 64'd0);
      chk("w1_off_cnt", off_cnt - off_base, 64'd1);
      chk("w1_off_frame", off_frame, 64'd6);
      bus.arm = 1'b0;
      @(negedge clk);
      chk("w1_idle", bus.st, 64'd0);

      // Unlimited window, then disarm
      zero_cnt();
      cfg(32'd1, 16'd0);
      bus.arm = 1'b1;
      @(negedge clk);
      on_base = on_cnt; off_base = off_cnt;
      frames(2);
      chk("w2_on_frame", on_frame, 64'd2);
      frames(100);
      chk("w2_en_100", bus.dump_en, 64'd1);
      chk("w2_st_100", bus.st, 64'd2);
      chk("w2_no_off", off_cnt - off_base, 64'd0);
      bus.arm = 1'b0;
      @(negedge clk);
      chk("w2_off_pulse", bus.dump_off, 64'd1);
      chk("w2_done", bus.st, 64'd3);
      @(negedge clk);
      chk("w2_off_width", bus.dump_off, 64'd0);
      chk("w2_idle", bus.st, 64'd0);
      @(negedge clk);
      chk("w2_one_off", off_cnt - off_base, 64'd1);

      // Download during a window, then re-arm with start 0
      zero_cnt();
      cfg(32'd0, 16'd0);
      bus.arm = 1'b1;
      @(negedge clk);
      frame();
      chk("w3_dump", bus.st, 64'd2);
      frames(2);
      bus.dwn = 1'b1;
      @(negedge clk);
      chk("w3_dwn_off", bus.dump_off, 64'd1);
      chk("w3_dwn_st", bus.st, 64'd3);
      chk("w3_dwn_cnt", bus.frame_cnt, 64'd0);
      frames(2);
      chk("w3_dwn_hold", bus.frame_cnt, 64'd0);
      bus.dwn = 1'b0;
      bus.arm = 1'b0;
      @(negedge clk);
      chk("w3_idle", bus.st, 64'd0);
      bus.arm = 1'b1;
      @(negedge clk);
      on_base = on_cnt;
      frame();
      chk("w3_rearm_st", bus.st, 64'd2);
      chk("w3_rearm_on", on_cnt - on_base, 64'd1);
      chk("w3_rearm_frame", on_frame, 64'd1);
      bus.arm = 1'b0;
      repeat (2) @(negedge clk);
      chk("w3_end_idle", bus.st, 64'd0);

      // Config write while armed is ignored
      zero_cnt();
      cfg(32'd2, 16'd1);
      bus.arm = 1'b1;
      @(negedge clk);
      cfg(32'd7, 16'd5);
      on_base = on_cnt;
      frames(3);
      chk("w4_trig_st", bus.st, 64'd2);
      chk("w4_trig_frame", on_frame, 64'd3);
      frame();
      chk("w4_len1_done", bus.st, 64'd3);

      // Start match coinciding with disarm
      bus.arm = 1'b0;
      @(negedge clk);
      zero_cnt();
      cfg(32'd1, 16'd0);
      bus.arm = 1'b1;
      @(negedge clk);
      frame();
      on_base = on_cnt;
      bus.vs = 1'b0; bus2.vs = 1'b0;
      repeat (2) @(negedge clk);
      bus.arm = 1'b0;
      @(negedge clk);
      chk("w5_idle", bus.st, 64'd0);
      chk("w5_cnt", bus.frame_cnt, 64'd2);
      bus.vs = 1'b1; bus2.vs = 1'b1;
      repeat (4) @(negedge clk);
      chk("w5_no_on", on_cnt - on_base, 64'd0);

      // Wrap on the narrow instance: 6 -> 7 -> 0, then start 0 matches
      bus2.dwn = 1'b1;
      repeat (2) @(negedge clk);
      bus2.dwn = 1'b0;
      @(negedge clk);
      frames(6);
      chk("wrap_cnt6", bus2.frame_cnt, 64'd6);
      bus2.cfg_start = 3'd0; bus2.cfg_len = 4'd1; bus2.cfg_we = 1'b1;
      @(negedge clk);
      bus2.cfg_we = 1'b0;
      bus2.arm = 1'b1;
      @(negedge clk);
      frames(2);
      chk("wrap_cnt0", bus2.frame_cnt, 64'd0);
      chk("wrap_armed", bus2.st, 64'd1);
      chk("wrap_no_on", on2_cnt, 64'd0);
      frame();
      chk("wrap_dump", bus2.st, 64'd2);
      chk("wrap_en", bus2.dump_en, 64'd1);
      chk("wrap_on", on2_cnt, 64'd1);
      frame();
      chk("wrap_done", bus2.st, 64'd3);

      // Asynchronous reset in the middle of a window
      zero_cnt();
      cfg(32'd0, 16'd0);
      bus.arm = 1'b1;
      @(negedge clk);
      frame();
      chk("ar_dump_en", bus.dump_en, 64'd1);
      off_base = off_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_en_clear", bus.dump_en, 64'd0);
      chk("ar_st_clear", bus.st, 64'd0);
      repeat (3) @(negedge clk);
      chk("ar_no_off", off_cnt - off_base, 64'd0);
      chk("never_both", both_cnt, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
